// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding, the queue entry layout and the reset/NOP words.
// No logic of its own; imported by the fetch unit and its queue.
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no request in flight
        ST_WAIT  = 2'd1,   // live request in flight
        ST_STALE = 2'd2    // request in flight whose response will be dropped
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Prefetch queue of {instruction, pc} entries with push/pop/flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: never refuses a push; the producer reserves slots via count, overflow is an error.
module fetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // A pop on an empty queue is ignored rather than corrupting the count.
    assign do_pop = pop && (count != '0);

    // Pointer and occupancy tracking; flush drops everything at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    // Head reads as a NOP at pc 0 when there is nothing to hand out.
    always_comb begin
        head      = '0;
        head.inst = NOP_WORD;
        if (count != '0) head = mem[rd_ptr];
    end

    // The issuer reserves a slot before requesting, so a push into a full queue means a broken reservation.
    assert property (@(posedge clock) disable iff (!reset) !(push && (count == FULL_CNT)))
        else $error("fetch_fifo: push into full queue");

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding memory request, prefetch queue, redirect flush.
// Latency: ack in cycle t reaches inst_valid at t+1; steady state one instruction per 2 cycles.
// Backpressure: inst_ready low fills the queue, after which no further requests are issued.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_state_t     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // The request is decided in the IDLE cycle itself so memory sees it on the next edge;
    // registering it would cost a cycle per fetch. Reset gates it so nothing leaves during reset.
    // Only IDLE issues, so the in-flight request is zero here and count alone reserves the slot.
    assign imem_req  = reset && (state == ST_IDLE) && !redirect && (count < DEPTH_CNT);
    assign imem_addr = fetch_pc[31:2];

    // Only a live response is kept; a redirect in the ack cycle discards it.
    assign push       = (state == ST_WAIT) && imem_ack && !redirect;
    assign push_entry = '{inst: imem_rdata, pc: req_pc};
    assign pop        = inst_valid && inst_ready;

    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    // Fetch FSM and PC: issue in IDLE, retire or drop the response, redirect overrides the PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A response for a request lost to reset lands here and is ignored.
                    if (imem_req) begin
                        state    <= ST_WAIT;
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack)      state <= ST_IDLE;
                    else if (redirect) state <= ST_STALE;
                end
                ST_STALE: begin
                    if (imem_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // No request issues in a redirect cycle, so this never races the increment above.
            if (redirect) fetch_pc <= align_pc(redirect_pc);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

endmodule
